// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - RV32I multi-cycle control FSM with memory timeout.
// Optional ILLEGAL_TRAP_EN: unknown opcodes halt and raise the sticky illegal flag.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [3:0] state_o,
  output logic       halted,
`ifdef ILLEGAL_TRAP_EN
  output logic       illegal,
`endif
  output logic       bus_err
);

  localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXER   = 4'd6,  S_EXEI   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JALR   = 4'd11;
  localparam logic [3:0] S_LINK   = 4'd12, S_LUI    = 4'd13, S_AUIPC  = 4'd14, S_HALT   = 4'd15;

  localparam bit TO_EN = (MEM_TIMEOUT > 0);
  localparam int CW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_EN ? MEM_TIMEOUT - 1 : 0);

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_err_q, bus_err_d;
  logic          waiting, timeout, taken;
`ifdef ILLEGAL_TRAP_EN
  logic          illegal_q, illegal_d;
  assign illegal = illegal_q;
`endif

  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR)) && !mem_ready;
  assign timeout = TO_EN && waiting && (cnt_q == TO_LAST);

  always_comb begin
    case (func3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bus_err_d = bus_err_q;
    cnt_d     = (TO_EN && waiting) ? cnt_q + CW'(1) : '0;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011: state_d = S_EXER;
          7'b0010011: state_d = S_EXEI;
          7'b1100011: state_d = S_BRANCH;
          7'b1101111: state_d = S_JAL;
          7'b1100111: state_d = S_JALR;
          7'b0110111: state_d = S_LUI;
          7'b0010111: state_d = S_AUIPC;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d   = S_HALT;
            illegal_d = 1'b1;
`else
            state_d   = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == 7'b0000011) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXER, S_EXEI, S_LUI, S_AUIPC, S_JAL, S_LINK: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
      S_JALR:   state_d = S_LINK;
      default:  state_d = state_q;
    endcase
    // A stalled memory access that runs out of budget abandons the instruction.
    if (timeout) begin
      state_d   = S_HALT;
      bus_err_d = 1'b1;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    case (state_q)
      S_FETCH:  begin
        mem_read = 1'b1; alu_src_b = 2'b10; result_src = 2'b10;
        ir_write = mem_ready; pc_write = mem_ready;
      end
      S_DECODE: begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
      S_MEMADR: begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      S_MEMRD:  begin mem_read = 1'b1; adr_src = 1'b1; end
      S_MEMWB:  begin result_src = 2'b01; reg_write = 1'b1; end
      S_MEMWR:  begin mem_write = 1'b1; adr_src = 1'b1; end
      S_EXER:   begin alu_src_a = 2'b10; alu_op = 2'b10; end
      S_EXEI:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = 2'b10; end
      S_ALUWB:  reg_write = 1'b1;
      S_BRANCH: begin alu_src_a = 2'b10; alu_op = 2'b01; pc_write = taken; end
      S_JAL:    begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_write = 1'b1; end
      S_JALR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; result_src = 2'b10; pc_write = 1'b1; end
      S_LINK:   begin alu_src_a = 2'b01; alu_src_b = 2'b10; end
      S_LUI:    begin alu_src_a = 2'b11; alu_src_b = 2'b01; end
      S_AUIPC:  begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
      default:  ;
    endcase
    if (!rst_n) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign state_o = state_q;
  assign halted  = (state_q == S_HALT);
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm.
module tb_multicycle_control_fsm;
  localparam int TO = 4;

  logic       clk, rst_n;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       zero, lt, ltu, mem_ready;
  logic       ir_write, pc_write, adr_src, mem_read, mem_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [3:0] state_o;
  logic       halted, bus_err;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  multicycle_control_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .zero(zero), .lt(lt),
    .ltu(ltu), .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
    .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
    .state_o(state_o), .halted(halted),
`ifdef ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .bus_err(bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: remaining state path per instruction class, plus stall/timeout bookkeeping.
  int m_st = 0;
  int m_wait = 0;
  bit m_berr = 1'b0;
  bit m_ill = 1'b0;
  int m_path[$];

  function automatic bit br_taken(input logic [2:0] f, input logic z, input logic l, input logic lu);
    if (f == 3'd0) return z;
    if (f == 3'd1) return !z;
    if (f == 3'd4) return l;
    if (f == 3'd5) return !l;
    if (f == 3'd6) return lu;
    if (f == 3'd7) return !lu;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_st = 0; m_wait = 0; m_berr = 0; m_ill = 0;
      m_path.delete();
    end else if (m_st == 0 || m_st == 3 || m_st == 5) begin
      if (mem_ready) begin
        m_wait = 0;
        if (m_st == 0) m_st = 1;
        else m_st = (m_path.size() > 0) ? m_path.pop_front() : 0;
      end else begin
        m_wait++;
        if (m_wait == TO) begin m_st = 15; m_berr = 1; m_wait = 0; end
      end
    end else if (m_st == 1) begin
      case (opcode)
        7'b0000011: m_path = '{2, 3, 4};
        7'b0100011: m_path = '{2, 5};
        7'b0110011: m_path = '{6, 8};
        7'b0010011: m_path = '{7, 8};
        7'b1100011: m_path = '{9};
        7'b1101111: m_path = '{10, 8};
        7'b1100111: m_path = '{11, 12, 8};
        7'b0110111: m_path = '{13, 8};
        7'b0010111: m_path = '{14, 8};
        default: begin
`ifdef ILLEGAL_TRAP_EN
          m_path = '{15};
          m_ill = 1;
`else
          m_path.delete();
`endif
        end
      endcase
      m_st = (m_path.size() > 0) ? m_path.pop_front() : 0;
    end else if (m_st != 15) begin
      m_st = (m_path.size() > 0) ? m_path.pop_front() : 0;
    end
  end

  // {ir, pc, adr, mrd, mwr, rw, a[2], b[2], op[2], rs[2]}
  function automatic logic [13:0] exp_vec(input int s);
    logic [13:0] v;
    v = '0;
    case (s)
      0:  v = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10};
      1:  v = {6'b0, 2'b01, 2'b01, 2'b00, 2'b00};
      2:  v = {6'b0, 2'b10, 2'b01, 2'b00, 2'b00};
      3:  v = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'b0};
      4:  v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b0, 2'b01};
      5:  v = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'b0};
      6:  v = {6'b0, 2'b10, 2'b00, 2'b10, 2'b00};
      7:  v = {6'b0, 2'b10, 2'b01, 2'b10, 2'b00};
      8:  v = {5'b0, 1'b1, 8'b0};
      9:  v = {6'b0, 2'b10, 2'b00, 2'b01, 2'b00};
      10: v = {1'b0, 1'b1, 4'b0, 2'b01, 2'b10, 2'b00, 2'b00};
      11: v = {1'b0, 1'b1, 4'b0, 2'b10, 2'b01, 2'b00, 2'b10};
      12: v = {6'b0, 2'b01, 2'b10, 2'b00, 2'b00};
      13: v = {6'b0, 2'b11, 2'b01, 2'b00, 2'b00};
      14: v = {6'b0, 2'b01, 2'b01, 2'b00, 2'b00};
      default: v = '0;
    endcase
    if (s == 0) begin v[13] = mem_ready; v[12] = mem_ready; end
    if (s == 9) v[12] = br_taken(func3, zero, lt, ltu);
    if (!rst_n) begin v[13] = 0; v[12] = 0; v[10] = 0; v[9] = 0; v[8] = 0; end
    return v;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      check("state", int'(state_o), m_st);
      check("outputs", int'({ir_write, pc_write, adr_src, mem_read, mem_write, reg_write,
                             alu_src_a, alu_src_b, alu_op, result_src}), int'(exp_vec(m_st)));
      check("halted", int'(halted), int'(m_st == 15));
      check("bus_err", int'(bus_err), int'(m_berr));
`ifdef ILLEGAL_TRAP_EN
      check("illegal", int'(illegal), int'(m_ill));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int seq[$];
  int cnt;
  logic [6:0] sweep_ops[6];

  initial begin
    rst_n = 0; opcode = 0; func3 = 0; zero = 0; lt = 0; ltu = 0; mem_ready = 1;
    cyc();
    started = 1;
    #1;
    check("rst_state", int'(state_o), 0);
    check("rst_mem_read_forced", int'(mem_read), 0);
    check("rst_bus_err", int'(bus_err), 0);

    // add x3,x1,x2
    rst_n = 1; opcode = 7'b0110011;
    seq = '{0, 1, 6, 8, 0};
    foreach (seq[i]) begin
      if (i > 0) cyc();
      #1;
      check($sformatf("add_state%0d", i), int'(state_o), seq[i]);
      check($sformatf("add_rw%0d", i), int'(reg_write), int'(seq[i] == 8));
    end

    // lw with three stall cycles in MEMRD
    opcode = 7'b0000011;
    cyc(); cyc(); cyc();
    mem_ready = 0; cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) mem_ready = 1;
      #1;
      if (state_o != 4'd3) break;
      if (mem_read) cnt++;
      cyc();
    end
    check("lw_mem_read_cycles", cnt, 4);
    check("lw_memwb_state", int'(state_o), 4);
    check("lw_memwb_rw", int'(reg_write), 1);
    check("lw_memwb_rs", int'(result_src), 1);
    cyc();

    // beq then bne, both with zero=1
    opcode = 7'b1100011; func3 = 3'b000; zero = 1;
    cyc(); cyc(); #1;
    check("beq_state", int'(state_o), 9);
    check("beq_pc_write", int'(pc_write), 1);
    cyc();
    func3 = 3'b001;
    cyc(); cyc(); #1;
    check("bne_state", int'(state_o), 9);
    check("bne_pc_write", int'(pc_write), 0);
    cyc();

    // jalr
    opcode = 7'b1100111; zero = 0;
    seq = '{0, 1, 11, 12, 8};
    foreach (seq[i]) begin
      if (i > 0) cyc();
      #1;
      check($sformatf("jalr_state%0d", i), int'(state_o), seq[i]);
      if (seq[i] == 11) check("jalr_pc_write", int'(pc_write), 1);
      if (seq[i] == 8) check("jalr_reg_write", int'(reg_write), 1);
    end
    cyc();

    // Model-checked sweep of remaining classes and all branch conditions
    sweep_ops = '{7'b1101111, 7'b0110111, 7'b0010111, 7'b0010011, 7'b0100011, 7'b1100011};
    foreach (sweep_ops[k]) begin
      for (int f = 0; f < 8; f++) begin
        opcode = sweep_ops[k]; func3 = 3'(f);
        for (int c = 0; c < 5; c++) begin
          {zero, lt, ltu} = 3'($urandom_range(0, 7));
          cyc();
        end
      end
    end

    // Reset in the middle of a stalled store
    rst_n = 0; cyc(); rst_n = 1;
    opcode = 7'b0100011; mem_ready = 1;
    cyc(); cyc(); cyc();
    mem_ready = 0; #1;
    check("sw_memwr_state", int'(state_o), 5);
    check("sw_mem_write", int'(mem_write), 1);
    cyc();
    rst_n = 0; #1;
    check("sw_rst_mem_write", int'(mem_write), 0);
    cyc(); #1;
    check("sw_rst_state", int'(state_o), 0);
    rst_n = 1; mem_ready = 1;

    // Unknown opcode
    opcode = 7'h7F;
    cyc(); cyc(); #1;
`ifdef ILLEGAL_TRAP_EN
    check("illegal_state", int'(state_o), 15);
    check("illegal_flag", int'(illegal), 1);
`else
    check("illegal_state", int'(state_o), 0);
`endif
    rst_n = 0; cyc(); rst_n = 1;

    // Fetch timeout
    opcode = 7'b0110011; mem_ready = 0; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (state_o != 4'd0) break;
      cnt++;
      cyc();
    end
    check("to_fetch_cycles", cnt, TO);
    check("to_state", int'(state_o), 15);
    check("to_bus_err", int'(bus_err), 1);
    check("to_halted", int'(halted), 1);
    mem_ready = 1;
    cyc(); cyc(); #1;
    check("to_halt_sticky", int'(state_o), 15);
    rst_n = 0; cyc(); #1;
    check("to_rst_bus_err", int'(bus_err), 0);
    rst_n = 1;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
